// File: rtl/offchip_load_sequencer.sv
// Off-chip load sequencer: streams one pixel word and W2_DEPTH weight words into
// the input and weight-2 SRAMs, then runs the layer controller for RUN_CYCLES cycles.
module offchip_load_sequencer #(
    parameter int PIX_W      = 90,
    parameter int W2_W       = 16,
    parameter int W2_DEPTH   = 16,
    parameter int W2_AW      = 4,
    parameter int RUN_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             w2_valid,
    output logic             w2_ready,
    input  logic [W2_W-1:0]  w2_data,
    output logic             input_sram_we,
    output logic [PIX_W-1:0] input_sram_data,
    output logic             w2_sram_we,
    output logic [W2_AW-1:0] w2_sram_addr,
    output logic [W2_W-1:0]  w2_sram_data,
    output logic             core_reset,
    output logic             busy,
    output logic             done
);

    localparam int                RUN_CW   = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [W2_AW-1:0]  W2_LAST  = W2_AW'(W2_DEPTH - 1);
    localparam logic [RUN_CW-1:0] RUN_LAST = RUN_CW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_PIX = 3'd1,
        ST_LOAD_W2  = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t             state_r;
    logic               pix_ready_r;
    logic               w2_ready_r;
    logic               input_sram_we_r;
    logic [PIX_W-1:0]   input_sram_data_r;
    logic               w2_sram_we_r;
    logic [W2_AW-1:0]   w2_sram_addr_r;
    logic [W2_W-1:0]    w2_sram_data_r;
    logic               core_reset_r;
    logic               busy_r;
    logic               done_r;
    logic [W2_AW-1:0]   w_cnt_r;
    logic [RUN_CW-1:0]  run_cnt_r;
    logic               pix_hs_s;
    logic               w2_hs_s;

    // Handshakes qualify valid with the registered ready, so ready never depends on valid.
    always_comb begin
        pix_hs_s = pix_valid & pix_ready_r;
        w2_hs_s  = w2_valid & w2_ready_r;
    end

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            pix_ready_r       <= 1'b0;
            w2_ready_r        <= 1'b0;
            input_sram_we_r   <= 1'b0;
            input_sram_data_r <= {PIX_W{1'b0}};
            w2_sram_we_r      <= 1'b0;
            w2_sram_addr_r    <= {W2_AW{1'b0}};
            w2_sram_data_r    <= {W2_W{1'b0}};
            core_reset_r      <= 1'b1;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            w_cnt_r           <= {W2_AW{1'b0}};
            run_cnt_r         <= {RUN_CW{1'b0}};
        end else begin
            // Write pulses last one cycle; data and address hold between pulses.
            input_sram_we_r <= 1'b0;
            w2_sram_we_r    <= 1'b0;
            if (pix_hs_s) begin
                input_sram_we_r   <= 1'b1;
                input_sram_data_r <= pix_data;
            end
            if (w2_hs_s) begin
                w2_sram_we_r   <= 1'b1;
                w2_sram_addr_r <= w_cnt_r;
                w2_sram_data_r <= w2_data;
                w_cnt_r        <= w_cnt_r + W2_AW'(1);
            end

            // A handshake accepted in the abort cycle still writes; only control is cut.
            if (abort) begin
                state_r      <= ST_IDLE;
                pix_ready_r  <= 1'b0;
                w2_ready_r   <= 1'b0;
                core_reset_r <= 1'b1;
                busy_r       <= 1'b0;
                done_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_r     <= ST_LOAD_PIX;
                            pix_ready_r <= 1'b1;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                        end
                    end
                    ST_LOAD_PIX: begin
                        if (pix_hs_s) begin
                            state_r     <= ST_LOAD_W2;
                            pix_ready_r <= 1'b0;
                            w2_ready_r  <= 1'b1;
                            w_cnt_r     <= {W2_AW{1'b0}};
                        end
                    end
                    ST_LOAD_W2: begin
                        if (w2_hs_s && (w_cnt_r == W2_LAST)) begin
                            state_r    <= ST_RUN;
                            w2_ready_r <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // First RUN cycle still holds the controller in reset; it is released next.
                        if (core_reset_r) begin
                            core_reset_r <= 1'b0;
                            run_cnt_r    <= {RUN_CW{1'b0}};
                        end else if (run_cnt_r == RUN_LAST) begin
                            state_r      <= ST_DONE;
                            core_reset_r <= 1'b1;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            run_cnt_r <= run_cnt_r + RUN_CW'(1);
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        pix_ready_r  <= 1'b0;
                        w2_ready_r   <= 1'b0;
                        core_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pix_ready       = pix_ready_r;
    assign w2_ready        = w2_ready_r;
    assign input_sram_we   = input_sram_we_r;
    assign input_sram_data = input_sram_data_r;
    assign w2_sram_we      = w2_sram_we_r;
    assign w2_sram_addr    = w2_sram_addr_r;
    assign w2_sram_data    = w2_sram_data_r;
    assign core_reset      = core_reset_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_offchip_load_sequencer.sv
// Scoreboard bench for offchip_load_sequencer: expected SRAM writes are queued as
// beats are offered and popped by a negedge monitor as write pulses appear.
module tb_offchip_load_sequencer;

    localparam int PIX_W      = 90;
    localparam int W2_W       = 16;
    localparam int W2_DEPTH   = 16;
    localparam int W2_AW      = 4;
    localparam int RUN_CYCLES = 64;
    // Start sampled at edge E -> done visible after edge E+82, i.e. cycle t+83 for start
    // in cycle t: an 84-cycle pass counting both the start and done cycles.
    localparam int DONE_EDGES = 1 + W2_DEPTH + 1 + RUN_CYCLES;
    localparam int FALL_EDGES = 1 + W2_DEPTH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             w2_valid;
    logic             w2_ready;
    logic [W2_W-1:0]  w2_data;
    logic             input_sram_we;
    logic [PIX_W-1:0] input_sram_data;
    logic             w2_sram_we;
    logic [W2_AW-1:0] w2_sram_addr;
    logic [W2_W-1:0]  w2_sram_data;
    logic             core_reset;
    logic             busy;
    logic             done;

    offchip_load_sequencer #(
        .PIX_W(PIX_W), .W2_W(W2_W), .W2_DEPTH(W2_DEPTH), .W2_AW(W2_AW), .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .w2_valid(w2_valid), .w2_ready(w2_ready), .w2_data(w2_data),
        .input_sram_we(input_sram_we), .input_sram_data(input_sram_data),
        .w2_sram_we(w2_sram_we), .w2_sram_addr(w2_sram_addr), .w2_sram_data(w2_sram_data),
        .core_reset(core_reset), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int fails = 0;

    logic [W2_AW-1:0] exp_addr_q[$];
    logic [W2_W-1:0]  exp_data_q[$];
    logic [PIX_W-1:0] exp_pix_q[$];

    int   w2_wr_cnt, pix_wr_cnt, cr_low_cnt, done_edge, cr_fall_edge, start_edge;
    int   prev_wr_edge, spacing_viol, hold_viol, ready_viol;
    logic in_w2_window, hold_chk, spacing_chk, have_last, cr_low_prev, done_prev;
    logic [W2_AW-1:0] last_exp_addr;

    task automatic clear_stats();
        w2_wr_cnt = 0; pix_wr_cnt = 0; cr_low_cnt = 0; done_edge = -1; cr_fall_edge = -1;
        prev_wr_edge = -1; spacing_viol = 0; hold_viol = 0; ready_viol = 0;
        in_w2_window = 1'b0; hold_chk = 1'b0; spacing_chk = 1'b0; have_last = 1'b0;
    endtask

    task automatic monitor();
        logic [W2_AW-1:0] pa;
        logic [W2_W-1:0]  pd;
        logic [PIX_W-1:0] pp;
        forever begin
            @(negedge clk);
            if (w2_sram_we === 1'b1) begin
                w2_wr_cnt++;
                n_vec++;
                if (exp_addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL w2_write_unexpected got addr=%0d data=%h, none expected", w2_sram_addr, w2_sram_data);
                end else begin
                    pa = exp_addr_q.pop_front();
                    pd = exp_data_q.pop_front();
                    if (w2_sram_addr !== pa || w2_sram_data !== pd) begin
                        fails++;
                        $display("FAIL w2_write got addr=%0d data=%h exp addr=%0d data=%h", w2_sram_addr, w2_sram_data, pa, pd);
                    end
                    last_exp_addr = pa;
                    have_last = 1'b1;
                    if (spacing_chk && prev_wr_edge >= 0 && (cyc - prev_wr_edge) != 2) spacing_viol++;
                    prev_wr_edge = cyc;
                end
            end else if (hold_chk && have_last && w2_sram_addr !== last_exp_addr) begin
                hold_viol++;
            end
            if (input_sram_we === 1'b1) begin
                pix_wr_cnt++;
                n_vec++;
                if (exp_pix_q.size() == 0) begin
                    fails++;
                    $display("FAIL pix_write_unexpected got data=%h", input_sram_data);
                end else begin
                    pp = exp_pix_q.pop_front();
                    if (input_sram_data !== pp) begin
                        fails++;
                        $display("FAIL pix_write got %h exp %h", input_sram_data, pp);
                    end
                end
            end
            if (core_reset === 1'b0) begin
                cr_low_cnt++;
                if (!cr_low_prev) cr_fall_edge = cyc;
            end
            if (done === 1'b1 && !done_prev) done_edge = cyc;
            cr_low_prev = (core_reset === 1'b0);
            done_prev   = (done === 1'b1);
            if (in_w2_window && w2_ready !== 1'b1) ready_viol++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic load_pixel(input logic [PIX_W-1:0] px);
        int n = 0;
        pix_data = px;
        pix_valid = 1'b1;
        exp_pix_q.push_back(px);
        while (pix_ready !== 1'b1 && n < 20) begin tick(); n++; end
        n_vec++;
        if (n == 20) begin fails++; $display("FAIL pix_ready_timeout got ready=%b exp 1", pix_ready); end
        tick();
        pix_valid = 1'b0;
        in_w2_window = 1'b1;
    endtask

    // stop_kind: 0 none, 1 abort, 2 reset, applied on beat stop_beat.
    task automatic load_weights(input logic [W2_W-1:0] base, input int throttle,
                                input int stop_beat, input int stop_kind, input int poke_beat);
        for (int i = 0; i < W2_DEPTH; i++) begin
            int n = 0;
            w2_data  = base + W2_W'(i);
            w2_valid = 1'b1;
            while (w2_ready !== 1'b1 && n < 20) begin tick(); n++; end
            n_vec++;
            if (n == 20) begin fails++; $display("FAIL w2_ready_timeout beat=%0d got ready=%b exp 1", i, w2_ready); end
            if (i == stop_beat && stop_kind == 2) begin
                reset = 1'b1;
            end else begin
                exp_addr_q.push_back(W2_AW'(i));
                exp_data_q.push_back(base + W2_W'(i));
            end
            if (i == stop_beat && stop_kind == 1) abort = 1'b1;
            if (i == poke_beat) start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            w2_valid = 1'b0;
            if (i == stop_beat) begin
                in_w2_window = 1'b0;
                return;
            end
            if (throttle != 0 && i != W2_DEPTH - 1) tick();
        end
        in_w2_window = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int poke_run);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            if (poke_run > 0 && n == poke_run) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        n_vec++;
        if (done !== 1'b1) begin fails++; $display("FAIL done_timeout got done=%b exp 1", done); end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [PIX_W-1:0] rand_pix();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PIX_W-1:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({pix_ready, w2_ready, input_sram_we, w2_sram_we, core_reset, busy, done} !== 7'b0000100) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp %b", {pix_ready, w2_ready, input_sram_we, w2_sram_we, core_reset, busy, done}, 7'b0000100);
        end
        n_vec++;
        if (input_sram_data !== {PIX_W{1'b0}} || w2_sram_addr !== {W2_AW{1'b0}} || w2_sram_data !== {W2_W{1'b0}}) begin
            fails++;
            $display("FAIL reset_data got pix=%h addr=%0d w2=%h exp all 0", input_sram_data, w2_sram_addr, w2_sram_data);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({pix_ready, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_start_ignored got ready,busy=%b exp 00", {pix_ready, busy});
        end
    endtask

    task automatic test_full_pass();
        clear_stats();
        issue_start();
        n_vec++;
        if ({pix_ready, busy, w2_ready} !== 3'b110) begin
            fails++;
            $display("FAIL full_start got ready,busy,w2r=%b exp 110", {pix_ready, busy, w2_ready});
        end
        load_pixel(rand_pix());
        load_weights(16'h0100, 0, -1, 0, -1);
        wait_done(300, 0);
        n_vec++;
        if (w2_wr_cnt != W2_DEPTH || pix_wr_cnt != 1 || exp_addr_q.size() != 0 || exp_pix_q.size() != 0) begin
            fails++;
            $display("FAIL full_writes got w2=%0d pix=%0d left=%0d exp w2=%0d pix=1 left=0", w2_wr_cnt, pix_wr_cnt, exp_addr_q.size(), W2_DEPTH);
        end
        n_vec++;
        if (cr_low_cnt != RUN_CYCLES) begin fails++; $display("FAIL full_core_low got %0d exp %0d", cr_low_cnt, RUN_CYCLES); end
        n_vec++;
        if (cr_fall_edge - start_edge != FALL_EDGES) begin
            fails++;
            $display("FAIL full_core_fall got %0d exp %0d", cr_fall_edge - start_edge, FALL_EDGES);
        end
        n_vec++;
        if (done_edge - start_edge != DONE_EDGES) begin
            fails++;
            $display("FAIL full_done_latency got %0d exp %0d", done_edge - start_edge, DONE_EDGES);
        end
        n_vec++;
        if ({core_reset, busy, ready_viol != 0} !== 3'b100) begin
            fails++;
            $display("FAIL full_end got core_reset,busy=%b ready_viol=%0d exp 10,0", {core_reset, busy}, ready_viol);
        end
    endtask

    task automatic test_throttled();
        clear_stats();
        hold_chk = 1'b1;
        spacing_chk = 1'b1;
        issue_start();
        load_pixel(rand_pix());
        load_weights(16'hFFF8, 1, -1, 0, -1);
        wait_done(300, 0);
        n_vec++;
        if (w2_wr_cnt != W2_DEPTH || exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL thr_writes got %0d left=%0d exp %0d left=0", w2_wr_cnt, exp_addr_q.size(), W2_DEPTH);
        end
        n_vec++;
        if (spacing_viol != 0 || hold_viol != 0 || ready_viol != 0) begin
            fails++;
            $display("FAIL thr_timing got spacing=%0d hold=%0d ready=%0d exp 0,0,0", spacing_viol, hold_viol, ready_viol);
        end
        n_vec++;
        if (done_edge - start_edge != DONE_EDGES + W2_DEPTH - 1) begin
            fails++;
            $display("FAIL thr_done_latency got %0d exp %0d", done_edge - start_edge, DONE_EDGES + W2_DEPTH - 1);
        end
    endtask

    task automatic test_ignored_start();
        clear_stats();
        issue_start();
        load_pixel(rand_pix());
        load_weights(16'h1234, 0, -1, 0, 5);
        wait_done(300, 10);
        n_vec++;
        if (w2_wr_cnt != W2_DEPTH || pix_wr_cnt != 1 || exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL ign_writes got w2=%0d pix=%0d exp %0d,1", w2_wr_cnt, pix_wr_cnt, W2_DEPTH);
        end
        n_vec++;
        if (cr_low_cnt != RUN_CYCLES || done_edge - start_edge != DONE_EDGES) begin
            fails++;
            $display("FAIL ign_timing got low=%0d lat=%0d exp %0d,%0d", cr_low_cnt, done_edge - start_edge, RUN_CYCLES, DONE_EDGES);
        end
    endtask

    task automatic test_rerun();
        clear_stats();
        issue_start();
        n_vec++;
        if ({done, core_reset, pix_ready} !== 3'b011) begin
            fails++;
            $display("FAIL rerun_start got done,core_reset,ready=%b exp 011", {done, core_reset, pix_ready});
        end
        load_pixel(rand_pix());
        load_weights(16'h0100, 0, -1, 0, -1);
        n_vec++;
        if (cr_low_cnt != 0) begin fails++; $display("FAIL rerun_reload_core got low=%0d exp 0", cr_low_cnt); end
        wait_done(300, 0);
        n_vec++;
        if (w2_wr_cnt != W2_DEPTH || cr_low_cnt != RUN_CYCLES || done_edge - start_edge != DONE_EDGES) begin
            fails++;
            $display("FAIL rerun_pass got w2=%0d low=%0d lat=%0d exp %0d,%0d,%0d", w2_wr_cnt, cr_low_cnt, done_edge - start_edge, W2_DEPTH, RUN_CYCLES, DONE_EDGES);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        issue_start();
        load_pixel(rand_pix());
        load_weights(16'h0300, 0, 7, 1, -1);
        n_vec++;
        if (w2_sram_we !== 1'b1 || w2_sram_addr !== 4'd7 || w2_sram_data !== 16'h0307) begin
            fails++;
            $display("FAIL abort_inflight got we=%b addr=%0d data=%h exp 1,7,0307", w2_sram_we, w2_sram_addr, w2_sram_data);
        end
        n_vec++;
        if ({core_reset, busy, done, w2_ready, pix_ready} !== 5'b10000) begin
            fails++;
            $display("FAIL abort_state got %b exp 10000", {core_reset, busy, done, w2_ready, pix_ready});
        end
        for (int k = 0; k < 6; k++) tick();
        n_vec++;
        if (w2_wr_cnt != 8 || exp_addr_q.size() != 0 || core_reset !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet got writes=%0d left=%0d core_reset=%b done=%b exp 8,0,1,0", w2_wr_cnt, exp_addr_q.size(), core_reset, done);
        end
        clear_stats();
        issue_start();
        load_pixel(rand_pix());
        load_weights(16'h0400, 0, -1, 0, -1);
        wait_done(300, 0);
        n_vec++;
        if (w2_wr_cnt != W2_DEPTH || exp_addr_q.size() != 0 || done_edge - start_edge != DONE_EDGES) begin
            fails++;
            $display("FAIL abort_restart got writes=%0d lat=%0d exp %0d,%0d", w2_wr_cnt, done_edge - start_edge, W2_DEPTH, DONE_EDGES);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        issue_start();
        load_pixel(rand_pix());
        load_weights(16'h0500, 0, 3, 2, -1);
        n_vec++;
        if ({pix_ready, w2_ready, input_sram_we, w2_sram_we, core_reset, busy, done} !== 7'b0000100 || w2_sram_addr !== {W2_AW{1'b0}}) begin
            fails++;
            $display("FAIL reset_mid got %b addr=%0d exp 0000100 addr 0", {pix_ready, w2_ready, input_sram_we, w2_sram_we, core_reset, busy, done}, w2_sram_addr);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_vec++;
        if (w2_wr_cnt != 3 || pix_wr_cnt != 1 || exp_addr_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_writes got w2=%0d pix=%0d busy=%b exp 3,1,0", w2_wr_cnt, pix_wr_cnt, busy);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pix_valid = 1'b0; pix_data = {PIX_W{1'b0}};
        w2_valid = 1'b0; w2_data = {W2_W{1'b0}};
        cr_low_prev = 1'b0; done_prev = 1'b0; last_exp_addr = {W2_AW{1'b0}};
        clear_stats();
        fork
            monitor();
        join_none
        test_reset();
        test_full_pass();
        test_throttled();
        test_ignored_start();
        test_rerun();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
